// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI master shifting WIDTH-bit words in all four modes with a programmable
// half-period divider and held slave selects. Define SPI_RXFIFO_EN to buffer received words.
module spi_shift_engine #(
    parameter int NSS        = 2,
    parameter int WIDTH      = 8,
    parameter int DIVW       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [WIDTH-1:0]      cmd_data,
    input  logic [$clog2(NSS):0]  cmd_ss,
    input  logic                  cmd_last,
    input  logic [1:0]            mode,
    input  logic [DIVW-1:0]       div,
    input  logic [NSS:0]          MISO,
    output logic                  MOSI,
    output logic                  SCK,
    output logic [NSS-1:0]        nSS,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [WIDTH-1:0]      rx_data,
    output logic                  busy
);

    localparam int SSW = $clog2(NSS) + 1;
    localparam int EW  = $clog2(2 * WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL} state_t;

    state_t           r_state;
    logic [DIVW-1:0]  r_cnt;
    logic [DIVW-1:0]  r_div;
    logic [EW-1:0]    r_edge;
    logic             r_cpha;
    logic             r_last;
    logic [SSW-1:0]   r_ss;
    logic [WIDTH-1:0] r_tx;
    logic [WIDTH-1:0] r_rx;
    logic             r_sck;
    logic [NSS-1:0]   r_nss;
    logic             r_busy;

    logic             w_hp_end;
    logic             w_last_edge;
    logic             w_edge_go;
    logic             w_edge_lead;
    logic             w_edge_first;
    logic             w_sample;
    logic             w_shift;
    logic             w_done;
    logic             w_full;
    logic             w_accept;
    logic             w_miso;
    logic [NSS-1:0]   w_sel;

    assign w_hp_end     = (r_cnt == r_div);
    assign w_last_edge  = (r_edge == EW'(2 * WIDTH - 1));
    assign w_edge_first = (r_state == S_LEAD);
    // An edge opens every SHIFT half-period; r_edge holds the half-period currently running.
    assign w_edge_go    = w_hp_end && ((r_state == S_LEAD) || ((r_state == S_SHIFT) && !w_last_edge));
    assign w_edge_lead  = w_edge_first || r_edge[0];
    assign w_sample     = w_edge_go && (w_edge_lead ^ r_cpha);
    assign w_shift      = w_edge_go && !(w_edge_lead ^ r_cpha) && !w_edge_first;
    assign w_done       = (r_state == S_TRAIL) && w_hp_end;
    assign w_accept     = cmd_valid && cmd_ready;

    assign cmd_ready = (r_state == S_IDLE) && !w_full;
    assign MOSI      = r_tx[WIDTH-1];
    assign SCK       = r_sck;
    assign nSS       = r_nss;
    assign busy      = r_busy;

    // Out-of-range slave indices deselect everything and listen on the spare MISO line.
    always_comb begin
        w_sel = '1;
        for (int i = 0; i < NSS; i++) begin
            if (cmd_ss == SSW'(i)) begin
                w_sel[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_miso = MISO[NSS];
        for (int i = 0; i < NSS; i++) begin
            if (r_ss == SSW'(i)) begin
                w_miso = MISO[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= '0;
            r_edge  <= '0;
            r_cpha  <= 1'b0;
            r_last  <= 1'b0;
            r_ss    <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_sck   <= 1'b0;
            r_nss   <= '1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_LEAD;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_div   <= div;
                        r_cpha  <= mode[0];
                        r_sck   <= mode[1];
                        r_last  <= cmd_last;
                        r_ss    <= cmd_ss;
                        r_tx    <= cmd_data;
                        r_nss   <= w_sel;
                    end
                end
                S_LEAD: begin
                    if (w_hp_end) begin
                        r_state <= S_SHIFT;
                        r_edge  <= '0;
                    end
                end
                S_SHIFT: begin
                    if (w_hp_end) begin
                        if (w_last_edge) begin
                            r_state <= S_TRAIL;
                        end else begin
                            r_edge <= r_edge + 1'b1;
                        end
                    end
                end
                S_TRAIL: begin
                    if (w_hp_end) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (r_last) begin
                            r_nss <= '1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (r_state != S_IDLE) begin
                r_cnt <= w_hp_end ? '0 : r_cnt + 1'b1;
            end
            if (w_edge_go) begin
                r_sck <= ~r_sck;
            end
            if (w_shift) begin
                r_tx <= {r_tx[WIDTH-2:0], 1'b0};
            end
            if (w_sample) begin
                r_rx <= {r_rx[WIDTH-2:0], w_miso};
            end
        end
    end

`ifdef SPI_RXFIFO_EN
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [PW:0]      r_fcnt;
    logic [WIDTH-1:0] r_head;

    logic             w_push;
    logic             w_pop;
    logic [PW-1:0]    w_rp_nxt;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push   = w_done;
    assign w_pop    = (r_fcnt != '0) && rx_ready;
    assign w_rp_nxt = f_inc(r_rp);
    assign w_full   = (r_fcnt == (PW + 1)'(FIFO_DEPTH));
    assign rx_valid = (r_fcnt != '0);
    assign rx_data  = r_head;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wp] <= r_rx;
        end
    end

    // r_head mirrors the entry at r_rp so rx_data comes straight from a register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_fcnt <= '0;
            r_head <= '0;
        end else begin
            if (w_push) begin
                r_wp <= f_inc(r_wp);
            end
            if (w_pop) begin
                r_rp <= w_rp_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + 1'b1;
                2'b01:   r_fcnt <= r_fcnt - 1'b1;
                default: r_fcnt <= r_fcnt;
            endcase
            if (w_pop && (r_fcnt > (PW + 1)'(1))) begin
                r_head <= r_mem[w_rp_nxt];
            end else if (w_push && ((r_fcnt == '0) || (w_pop && (r_fcnt == (PW + 1)'(1))))) begin
                r_head <= r_rx;
            end
        end
    end
`else
    logic             r_rx_valid;
    logic [WIDTH-1:0] r_rx_data;
    logic             w_unused;

    assign w_unused = rx_ready | (FIFO_DEPTH == 0);
    assign w_full   = 1'b0;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_rx_valid <= w_done;
            if (w_done) begin
                r_rx_data <= r_rx;
            end
        end
    end
`endif

endmodule
